// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for a word-wide, byte-strobed data memory.
// Misaligned accesses are split into two beats; define MISALIGN_TRAP_EN to flag them instead.
module mem_access_unit #(
  parameter int AW = 18,
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reqvalidM,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic [2:0]    memctrlM,
  input  logic [AW-1:0] addrM,
  input  logic [WD-1:0] writedataM,
  output logic          stallM,
  output logic [AW-1:0] dm_addr,
  output logic          dm_we,
  output logic [3:0]    dm_wstrb,
  output logic [WD-1:0] dm_wdata,
  input  logic [WD-1:0] dm_rdata,
  output logic          respvalidW,
  output logic [WD-1:0] loaddataW,
  output logic          misalignW
);

  typedef enum logic {S_IDLE, S_SPLIT} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e          state, next_state;
  size_e           size;
  logic            uns, misaligned, accept, is_store, is_load;
  logic [1:0]      off;
  logic [3:0]      mask;
  logic [7:0]      lane_mask;
  logic [2*WD-1:0] wdata_wide;
  logic [AW-1:0]   word_addr;
  logic [WD-1:0]   aligned_raw, merged_raw;

  // Beat-1 context: captured when a misaligned access is accepted, consumed in SPLIT.
  logic [WD-1:0]   cap_rdata, b1_wdata;
  logic [AW-1:0]   b1_addr;
  logic [3:0]      b1_strb;
  logic [1:0]      b1_off;
  logic            b1_store, b1_load, b1_uns;
  size_e           b1_size;

  function automatic logic [WD-1:0] extend(input logic [WD-1:0] raw, input size_e sz,
                                           input logic zext);
    case (sz)
      SZ_B:    extend = zext ? {{(WD-8){1'b0}}, raw[7:0]}   : {{(WD-8){raw[7]}}, raw[7:0]};
      SZ_H:    extend = zext ? {{(WD-16){1'b0}}, raw[15:0]} : {{(WD-16){raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Illegal funct3 codes fall into the default arm and behave as W.
  always_comb begin
    case (memctrlM)
      3'b000, 3'b100: size = SZ_B;
      3'b001, 3'b101: size = SZ_H;
      default:        size = SZ_W;
    endcase
    uns         = memctrlM[2] && (size != SZ_W);
    off         = addrM[1:0];
    misaligned  = ((size == SZ_H) && (off == 2'b11)) || ((size == SZ_W) && (off != 2'b00));
    mask        = (size == SZ_B) ? 4'b0001 : (size == SZ_H) ? 4'b0011 : 4'b1111;
    lane_mask   = {4'b0000, mask} << off;
    wdata_wide  = {{WD{1'b0}}, writedataM} << {off, 3'b000};
    word_addr   = {addrM[AW-1:2], 2'b00};
    is_store    = memwriteM;
    is_load     = memreadM && !memwriteM;
    accept      = (state == S_IDLE) && reqvalidM && (memreadM || memwriteM);
    aligned_raw = dm_rdata >> {off, 3'b000};
    merged_raw  = WD'({dm_rdata, cap_rdata} >> {b1_off, 3'b000});
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    stallM     = 1'b0;
    dm_addr    = word_addr;
    dm_we      = 1'b0;
    dm_wstrb   = 4'b0000;
    dm_wdata   = wdata_wide[WD-1:0];
    case (state)
      S_IDLE: begin
        if (accept) begin
          dm_we    = is_store;
          dm_wstrb = is_store ? lane_mask[3:0] : 4'b0000;
          if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
            dm_we    = 1'b0;
            dm_wstrb = 4'b0000;
`else
            stallM     = 1'b1;
            next_state = S_SPLIT;
`endif
          end
        end
      end
      S_SPLIT: begin
        dm_addr    = b1_addr;
        dm_we      = b1_store;
        dm_wstrb   = b1_store ? b1_strb : 4'b0000;
        dm_wdata   = b1_wdata;
        next_state = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      respvalidW <= 1'b0;
      loaddataW  <= '0;
      cap_rdata  <= '0;
      b1_wdata   <= '0;
      b1_addr    <= '0;
      b1_strb    <= 4'b0000;
      b1_off     <= 2'b00;
      b1_store   <= 1'b0;
      b1_load    <= 1'b0;
      b1_uns     <= 1'b0;
      b1_size    <= SZ_W;
    end else begin
      state      <= next_state;
      respvalidW <= 1'b0;
      if (accept && !misaligned && is_load) begin
        respvalidW <= 1'b1;
        loaddataW  <= extend(aligned_raw, size, uns);
      end
      if (accept && misaligned) begin
        cap_rdata <= dm_rdata;
        b1_wdata  <= wdata_wide[2*WD-1:WD];
        b1_addr   <= word_addr + AW'(4);
        b1_strb   <= lane_mask[7:4];
        b1_off    <= off;
        b1_store  <= is_store;
        b1_load   <= is_load;
        b1_uns    <= uns;
        b1_size   <= size;
      end
      if ((state == S_SPLIT) && b1_load) begin
        respvalidW <= 1'b1;
        loaddataW  <= extend(merged_raw, b1_size, b1_uns);
      end
`ifdef MISALIGN_TRAP_EN
      if (accept && misaligned && is_load) begin
        respvalidW <= 1'b1;
        loaddataW  <= '0;
      end
`endif
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalignW <= 1'b0;
    else     misalignW <= accept && misaligned;
  end
`else
  assign misalignW = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a behavioural byte-strobed memory.
// Build with +define+MISALIGN_TRAP_EN to exercise the trap configuration instead of splitting.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int AW = 18;
  localparam int WD = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqvalidM, memreadM, memwriteM;
  logic [2:0]    memctrlM;
  logic [AW-1:0] addrM;
  logic [WD-1:0] writedataM;
  logic          stallM;
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic [3:0]    dm_wstrb;
  logic [WD-1:0] dm_wdata, dm_rdata;
  logic          respvalidW;
  logic [WD-1:0] loaddataW;
  logic          misalignW;

  mem_access_unit #(.AW(AW), .WD(WD)) dut (
    .clk(clk), .rst(rst), .reqvalidM(reqvalidM), .memreadM(memreadM), .memwriteM(memwriteM),
    .memctrlM(memctrlM), .addrM(addrM), .writedataM(writedataM), .stallM(stallM),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .respvalidW(respvalidW), .loaddataW(loaddataW), .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WD-1:0] data; int due; logic mis; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [3:0] strb; logic [WD-1:0] data; } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Behavioural memory: combinational read, strobed write on the rising edge.
  logic [WD-1:0] mem [0:(1<<(AW-2))-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [WD-1:0] pl_data;
  logic [WD-1:0] merged_word;

  assign dm_rdata = mem[dm_addr[AW-1:2]];

  always_comb begin
    merged_word = dm_rdata;
    for (int i = 0; i < 4; i++)
      if (dm_wstrb[i]) merged_word[8*i +: 8] = dm_wdata[8*i +: 8];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr[AW-1:2]] <= pl_data;
    else if (dm_we) begin
      mem[dm_addr[AW-1:2]] <= merged_word;
      wr_q.push_back('{dm_addr, dm_wstrb, dm_wdata});
    end
  end

  // Response scoreboard and idle-cycle monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (respvalidW) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: loaddataW=%h at cycle %0d, want no response", loaddataW, cyc);
        end else begin
          e = exp_q.pop_front();
          if (loaddataW !== e.data || cyc !== e.due || misalignW !== e.mis) begin
            errors++;
            $display("FAIL load_resp: data=%h cyc=%0d mis=%b, want data=%h cyc=%0d mis=%b",
                     loaddataW, cyc, misalignW, e.data, e.due, e.mis);
          end
        end
      end
      if (!reqvalidM) begin
        checks++;
        if (dm_we !== 1'b0 || dm_wstrb !== 4'b0000 || stallM !== 1'b0) begin
          errors++;
          $display("FAIL idle_quiet: dm_we=%b dm_wstrb=%b stallM=%b, want 0/0000/0", dm_we, dm_wstrb, stallM);
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    reqvalidM = 1'b0; memreadM = 1'b0; memwriteM = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WD-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] ctrl,
                       input logic [AW-1:0] a, input logic [WD-1:0] d);
    @(negedge clk);
    reqvalidM = 1'b1; memreadM = rd; memwriteM = wr; memctrlM = ctrl; addrM = a; writedataM = d;
    #1;
  endtask

  task automatic load(input string name, input logic [2:0] ctrl, input logic [AW-1:0] a,
                      input logic [WD-1:0] exp, input logic split);
    drive(1'b1, 1'b0, ctrl, a, '0);
    checks++;
    if (stallM !== split || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_req: stallM=%b dm_we=%b, want stallM=%b dm_we=0", name, stallM, dm_we, split);
    end
    exp_q.push_back('{exp, cyc + (split ? 2 : 1), 1'b0});
    @(posedge clk);
    if (split) @(posedge clk);
  endtask

  task automatic store(input string name, input logic rd, input logic [2:0] ctrl,
                       input logic [AW-1:0] a, input logic [WD-1:0] d, input logic split);
    drive(rd, 1'b1, ctrl, a, d);
    checks++;
    if (stallM !== split || dm_we !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: stallM=%b dm_we=%b, want stallM=%b dm_we=1", name, stallM, dm_we, split);
    end
    @(posedge clk);
    if (split) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (respvalidW !== 1'b0 || loaddataW !== '0 || misalignW !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: respvalidW=%b loaddataW=%h misalignW=%b, want 0/0/0", respvalidW, loaddataW, misalignW);
    end
    checks++;
    if (stallM !== 1'b0 || dm_we !== 1'b0 || dm_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mem: stallM=%b dm_we=%b dm_wstrb=%b, want 0/0/0000", stallM, dm_we, dm_wstrb);
    end
    rst = 1'b0;
  endtask

  task automatic test_aligned_loads();
    load("lb_101",   3'b000, 18'h00101, 32'hFFFFFFAA, 1'b0);
    load("lbu_101",  3'b100, 18'h00101, 32'h000000AA, 1'b0);
    load("lh_102",   3'b001, 18'h00102, 32'hFFFF8899, 1'b0);
    load("lhu_102",  3'b101, 18'h00102, 32'h00008899, 1'b0);
    load("lh_100",   3'b001, 18'h00100, 32'hFFFFAABB, 1'b0);
    load("lw_100",   3'b010, 18'h00100, 32'h8899AABB, 1'b0);
    load("ill_100",  3'b111, 18'h00100, 32'h8899AABB, 1'b0);
    idle();
  endtask

  task automatic test_aligned_stores();
    drive(1'b0, 1'b1, 3'b001, 18'h00202, 32'h00001234);
    checks++;
    if (stallM !== 1'b0 || dm_we !== 1'b1 || dm_addr !== 18'h00200) begin
      errors++;
      $display("FAIL sh_202_ctl: stallM=%b dm_we=%b dm_addr=%h, want 0/1/00200", stallM, dm_we, dm_addr);
    end
    checks++;
    if (dm_wstrb !== 4'b1100 || dm_wdata[31:16] !== 16'h1234) begin
      errors++;
      $display("FAIL sh_202_lane: dm_wstrb=%b dm_wdata=%h, want 1100 with [31:16]=1234", dm_wstrb, dm_wdata);
    end
    @(posedge clk);
    store("sb_201", 1'b0, 3'b000, 18'h00201, 32'hFFFFFF5A, 1'b0);
    idle();
    checks++;
    if (wr_q.size() == 0 || wr_q[wr_q.size()-1].strb !== 4'b0010) begin
      errors++;
      $display("FAIL sb_201_strb: writes=%0d, want last strobe 0010", wr_q.size());
    end
    load("lw_200", 3'b010, 18'h00200, 32'h12345AA5, 1'b0);
    idle();
  endtask

  task automatic test_store_wins();
    store("both_400", 1'b1, 3'b010, 18'h00400, 32'h11223344, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    load("lw_400", 3'b010, 18'h00400, 32'h11223344, 1'b0);
    idle();
  endtask

  task automatic test_back_to_back();
    load("b2b_0", 3'b100, 18'h00100, 32'h000000BB, 1'b0);
    load("b2b_1", 3'b000, 18'h00101, 32'hFFFFFFAA, 1'b0);
    load("b2b_2", 3'b100, 18'h00102, 32'h00000099, 1'b0);
    load("b2b_3", 3'b000, 18'h00103, 32'hFFFFFF88, 1'b0);
    idle();
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_trap();
    preload(18'h00000, 32'h12345678);
    wr_q.delete();
    drive(1'b1, 1'b0, 3'b001, 18'h00003, '0);
    checks++;
    if (stallM !== 1'b0 || dm_we !== 1'b0 || dm_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL trap_lh_ctl: stallM=%b dm_we=%b dm_wstrb=%b, want 0/0/0000", stallM, dm_we, dm_wstrb);
    end
    exp_q.push_back('{32'h0, cyc + 1, 1'b1});
    @(posedge clk);
    drive(1'b0, 1'b1, 3'b010, 18'h00001, 32'hCAFEBABE);
    checks++;
    if (stallM !== 1'b0 || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL trap_sw_ctl: stallM=%b dm_we=%b, want 0/0", stallM, dm_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (misalignW !== 1'b1 || respvalidW !== 1'b0) begin
      errors++;
      $display("FAIL trap_sw_flag: misalignW=%b respvalidW=%b, want 1/0", misalignW, respvalidW);
    end
    idle();
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL trap_no_write: writes=%0d, want 0", wr_q.size());
    end
    load("trap_lw_0", 3'b010, 18'h00000, 32'h12345678, 1'b0);
    idle();
  endtask
`else
  task automatic test_split_load();
    drive(1'b1, 1'b0, 3'b010, 18'h00302, '0);
    checks++;
    if (stallM !== 1'b1 || dm_addr !== 18'h00300) begin
      errors++;
      $display("FAIL lw_302_beat0: stallM=%b dm_addr=%h, want 1/00300", stallM, dm_addr);
    end
    exp_q.push_back('{32'h66554433, cyc + 2, 1'b0});
    @(posedge clk);
    #1;
    checks++;
    if (stallM !== 1'b0 || dm_addr !== 18'h00304 || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_302_beat1: stallM=%b dm_addr=%h dm_we=%b, want 0/00304/0", stallM, dm_addr, dm_we);
    end
    @(posedge clk);
    load("lw_301",  3'b010, 18'h00301, 32'h55443322, 1'b1);
    load("lh_303",  3'b001, 18'h00303, 32'h00005544, 1'b1);
    load("lhu_307", 3'b101, 18'h00307, 32'h0000F188, 1'b1);
    load("lh_307",  3'b001, 18'h00307, 32'hFFFFF188, 1'b1);
    load("lb_300",  3'b000, 18'h00300, 32'h00000011, 1'b0);
    idle();
  endtask

  task automatic test_wrap_store();
    wr_q.delete();
    drive(1'b0, 1'b1, 3'b010, 18'h3FFFF, 32'hDEADBEEF);
    checks++;
    if (stallM !== 1'b1 || dm_addr !== 18'h3FFFC || dm_wstrb !== 4'b1000 || dm_wdata[31:24] !== 8'hEF) begin
      errors++;
      $display("FAIL sw_wrap_beat0: stallM=%b dm_addr=%h dm_wstrb=%b dm_wdata=%h, want 1/3fffc/1000/ef......",
               stallM, dm_addr, dm_wstrb, dm_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (stallM !== 1'b0 || dm_addr !== 18'h00000 || dm_wstrb !== 4'b0111 || dm_wdata[23:0] !== 24'hDEADBE) begin
      errors++;
      $display("FAIL sw_wrap_beat1: stallM=%b dm_addr=%h dm_wstrb=%b dm_wdata=%h, want 0/00000/0111/..deadbe",
               stallM, dm_addr, dm_wstrb, dm_wdata);
    end
    @(posedge clk);
    idle();
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL sw_wrap_beats: writes=%0d, want 2", wr_q.size());
    end
    load("lw_0",      3'b010, 18'h00000, 32'h11DEADBE, 1'b0);
    load("lw_3fffc",  3'b010, 18'h3FFFC, 32'hEF222222, 1'b0);
    load("lb_3ffff",  3'b000, 18'h3FFFF, 32'hFFFFFFEF, 1'b0);
    idle();
  endtask

  task automatic test_reset_in_split();
    wr_q.delete();
    drive(1'b0, 1'b1, 3'b010, 18'h00502, 32'hCAFEF00D);
    checks++;
    if (stallM !== 1'b1 || dm_wstrb !== 4'b1100) begin
      errors++;
      $display("FAIL rst_split_beat0: stallM=%b dm_wstrb=%b, want 1/1100", stallM, dm_wstrb);
    end
    @(posedge clk);
    #1;
    rst = 1'b1; reqvalidM = 1'b0; memwriteM = 1'b0;
    #1;
    checks++;
    if (dm_we !== 1'b0 || dm_wstrb !== 4'b0000 || stallM !== 1'b0 || respvalidW !== 1'b0) begin
      errors++;
      $display("FAIL rst_split_quiet: dm_we=%b dm_wstrb=%b stallM=%b respvalidW=%b, want 0/0000/0/0",
               dm_we, dm_wstrb, stallM, respvalidW);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != 1 || wr_q[0].addr !== 18'h00500 || wr_q[0].strb !== 4'b1100) begin
      errors++;
      $display("FAIL rst_split_writes: writes=%0d, want exactly beat 0 to 00500 strobe 1100", wr_q.size());
    end
    load("lw_500", 3'b010, 18'h00500, 32'hF00D0000, 1'b0);
    load("lw_504", 3'b010, 18'h00504, 32'h5A5A5A5A, 1'b0);
    idle();
  endtask
`endif

  initial begin
    rst = 1'b1; reqvalidM = 1'b0; memreadM = 1'b0; memwriteM = 1'b0;
    memctrlM = 3'b000; addrM = '0; writedataM = '0; pl_addr = '0; pl_data = '0;
    test_reset();
    preload(18'h00100, 32'h8899AABB);
    preload(18'h00200, 32'hA5A5A5A5);
    preload(18'h00400, 32'h00000000);
    test_aligned_loads();
    test_aligned_stores();
    test_store_wins();
    test_back_to_back();
`ifdef MISALIGN_TRAP_EN
    test_trap();
`else
    preload(18'h00300, 32'h44332211);
    preload(18'h00304, 32'h88776655);
    preload(18'h00308, 32'h000000F1);
    preload(18'h00000, 32'h11111111);
    preload(18'h3FFFC, 32'h22222222);
    preload(18'h00500, 32'h00000000);
    preload(18'h00504, 32'h5A5A5A5A);
    test_split_load();
    test_wrap_store();
    test_reset_in_split();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter AW, default 18, byte-address width of the data memory.
REQ-002 SHALL have parameter WD, default 32, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port reqvalidM  input  1  memory request present this cycle.
REQ-006 SHALL have port memreadM  input  1  request is a load.
REQ-007 SHALL have port memwriteM  input  1  request is a store.
REQ-008 SHALL have port memctrlM  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
REQ-009 SHALL have port addrM  input  AW  byte address.
REQ-010 SHALL have port writedataM  input  WD  store data, right-aligned.
REQ-011 SHALL have port stallM  output  1  hold request and upstream pipeline.
REQ-012 SHALL have port dm_addr  output  AW  word-aligned address to data memory; bits [1:0] are 00.
REQ-013 SHALL have port dm_we  output  1  data-memory write enable.
REQ-014 SHALL have port dm_wstrb  output  4  byte-lane write strobes.
REQ-015 SHALL have port dm_wdata  output  WD  lane-positioned store data.
REQ-016 SHALL have port dm_rdata  input  WD  combinational read word at dm_addr.
REQ-017 SHALL have port respvalidW  output  1  load result valid, one-cycle pulse.
REQ-018 SHALL have port loaddataW  output  WD  extended load result.
REQ-019 SHALL have port misalignW  output  1  misaligned-access flag (REQ-032 only).

Function
REQ-020 SHALL accept a request in any IDLE cycle with reqvalidM=1 and memreadM or memwriteM set; if both are set, the store wins and no load response is produced.
REQ-021 SHALL treat an access as aligned when it lies within one word: B always; H when addr[1:0]!=11; W when addr[1:0]=00.
REQ-022 SHALL, for an aligned access, drive dm_addr/dm_we/dm_wstrb/dm_wdata in the request cycle T with stallM=0, and for loads drive respvalidW=1 and loaddataW at T+1.
REQ-023 SHALL set strobes to lane addr[1:0] for B, lanes addr[1:0] and addr[1:0]+1 for H, and 1111 for W; it SHALL shift writedataM into the matching lanes.
REQ-024 SHALL, for a misaligned access, issue beat 0 at T to word addr[AW-1:2], covering lanes addr[1:0]..3, and beat 1 at T+1 to the next word, covering the remaining low lanes; the next-word address SHALL wrap modulo 2^AW.
REQ-025 SHALL drive stallM=1 combinationally during T and 0 at T+1 for a misaligned access; the requester holds inputs stable while stallM=1.
REQ-026 SHALL use FSM states IDLE->SPLIT (misaligned accepted)->IDLE (after beat 1); aligned accesses stay in IDLE.
REQ-027 SHALL capture beat-0 read lanes in a register at T and merge them with beat-1 lanes; for loads it SHALL pulse respvalidW at T+2.
REQ-028 SHALL sign-extend B and H loads and zero-extend BU and HU loads; W loads pass through unchanged.
REQ-029 SHALL treat illegal memctrlM codes as W for width and sign handling.
REQ-030 SHALL hold dm_we=0, dm_wstrb=0000 and stallM=0 in every cycle without an accepted request.

Reset
REQ-031 SHALL, on rst, force state IDLE, respvalidW=0, loaddataW=0, misalignW=0 and clear the beat-0 capture register; if rst asserts in SPLIT, beat 1 SHALL NOT be issued, and a beat-0 store already committed SHALL stay committed.

Configuration
REQ-032 SHALL, when MISALIGN_TRAP_EN is defined, skip splitting misaligned accesses: no memory write, stallM=0, and at T+1 misalignW=1, respvalidW=1 for loads, loaddataW=0.
REQ-033 SHALL, when MISALIGN_TRAP_EN is undefined, split per REQ-024..027, tie misalignW to 0 and omit the trap logic.

Verification
REQ-034 SHALL cover: mem[0x100]=0x8899AABB, LB addr 0x101 -> respvalidW at T+1, loaddataW=0xFFFFFFAA; LBU -> 0x000000AA.
REQ-035 SHALL cover: SH 0x1234 at addr 0x202 -> single cycle, dm_wstrb=1100, dm_wdata[31:16]=0x1234, stallM=0.
REQ-036 SHALL cover: mem[0x300]=0x44332211, mem[0x304]=0x88776655, LW addr 0x302 -> stallM=1 for one cycle, loaddataW=0x66554433 at T+2.
REQ-037 SHALL cover: SW 0xDEADBEEF at addr 0x3FFFF -> beat 0 to word 0x3FFFC with strobe 1000, beat 1 to word 0x00000 with strobe 0111.
REQ-038 SHALL cover: rst asserted during SPLIT of a misaligned SW -> no beat-1 write, state IDLE, respvalidW=0.
REQ-039 SHALL cover: with MISALIGN_TRAP_EN, LH addr 0x003 -> misalignW=1 and loaddataW=0 at T+1, no memory write.
